// File: rtl/led_frame_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : led_frame_sequencer
// Brief    : Sequences per-LED GRB words from a colour table into the WS2812B
//            shift/NZR datapath, then holds the latch gap. Optional continuous
//            refresh is enabled with the LED_AUTO_REFRESH_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
module led_frame_sequencer #(
    parameter int MAX_LEDS     = 8,
    parameter int AW           = 3,
    parameter int LATCH_CYCLES = 28100,
    parameter int CW           = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [23:0]   wr_data_i,
    input  logic [AW:0]   num_leds_i,
    input  logic          start_i,
    input  logic          stop_i,
    output logic [23:0]   grb_word_o,
    output logic          load_word_o,
    input  logic          word_done_i,
    output logic          busy_o,
    output logic          frame_done_o
);

    localparam logic [1:0]    S_IDLE       = 2'd0;
    localparam logic [1:0]    S_LOAD       = 2'd1;
    localparam logic [1:0]    S_SEND       = 2'd2;
    localparam logic [1:0]    S_LATCH      = 2'd3;
    localparam logic [AW:0]   C_MAX_N      = (AW+1)'(MAX_LEDS);
    localparam logic [CW-1:0] C_LATCH_LAST = CW'(LATCH_CYCLES - 1);

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] idx_q,   idx_d;
    logic [AW:0]   n_q,     n_d;
    logic [CW-1:0] latch_q, latch_d;
    logic [23:0]   grb_q,   grb_d;
    logic [23:0]   table_q [MAX_LEDS];

    logic [AW:0]   w_n_capped;
    logic          w_last_word;
    logic          w_latch_end;
    logic          w_wr_ok;
    logic          w_refresh;
    logic [23:0]   w_rd;

    assign w_n_capped  = (num_leds_i > C_MAX_N) ? C_MAX_N : num_leds_i;
    assign w_last_word = ({1'b0, idx_q} == (n_q - (AW+1)'(1)));
    assign w_latch_end = (latch_q == C_LATCH_LAST);
    assign w_wr_ok     = ({1'b0, wr_addr_i} < C_MAX_N);
    assign w_rd        = table_q[idx_q];

`ifdef LED_AUTO_REFRESH_EN
    logic stop_seen_q;

    // Sticky stop request; the frame in flight finishes before returning to IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stop_seen_q <= 1'b0;
        end else if (state_q == S_IDLE) begin
            stop_seen_q <= 1'b0;
        end else if (stop_i) begin
            stop_seen_q <= 1'b1;
        end
    end

    assign w_refresh = !(stop_seen_q || stop_i);
`else
    logic w_unused_stop;
    assign w_unused_stop = stop_i;
    assign w_refresh     = 1'b0;
`endif

    // Colour table is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en_i && w_wr_ok) begin
            table_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            n_q     <= '0;
            latch_q <= '0;
            grb_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            latch_q <= latch_d;
            grb_q   <= grb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        n_d     = n_q;
        latch_d = latch_q;
        grb_d   = grb_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    n_d     = w_n_capped;
                    idx_d   = '0;
                    latch_d = '0;
                    state_d = (w_n_capped != '0) ? S_LOAD : S_LATCH;
                end
            end
            S_LOAD: begin
                grb_d   = w_rd;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (word_done_i) begin
                    if (w_last_word) begin
                        latch_d = '0;
                        state_d = S_LATCH;
                    end else begin
                        idx_d   = idx_q + AW'(1);
                        state_d = S_LOAD;
                    end
                end
            end
            default: begin
                latch_d = latch_q + CW'(1);
                if (w_latch_end) begin
                    latch_d = '0;
                    if (w_refresh) begin
                        n_d     = w_n_capped;
                        idx_d   = '0;
                        state_d = (w_n_capped != '0) ? S_LOAD : S_LATCH;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
        endcase
    end

    // The table is read combinationally in LOAD so a write one cycle earlier is seen.
    always_comb begin
        load_word_o  = (state_q == S_LOAD);
        busy_o       = (state_q != S_IDLE);
        frame_done_o = (state_q == S_LATCH) && w_latch_end;
        grb_word_o   = (state_q == S_LOAD) ? w_rd : grb_q;
    end

endmodule
`default_nettype wire
